// File: rtl/apb_ram_slave.sv
// apb_ram_slave: APB slave backed by a resettable word-addressed RAM.
// Define APB_RAM_SLAVE_PSTRB_EN to honour PSTRB byte-lane write strobes.
module apb_ram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    PCLK,
    input  logic                    RST,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(NBYTES);
    localparam int IDX_W  = ADDR_WIDTH - OFFS;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACCESS = 1'b1;

    logic                  state_q,  state_d;
    logic [3:0]            cnt_q,    cnt_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic                  wr_q,     wr_d;
    logic                  err_q,    err_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [NBYTES-1:0]     strb_q,   strb_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [IDX_W-1:0]      req_idx;
    logic                  req_hit;
    logic [DATA_WIDTH-1:0] req_rdata;
    logic                  done;
    logic [DATA_WIDTH-1:0] wmask;
    logic                  unused_bits;

    // Word index drops the byte-offset bits of the address.
    assign req_idx = PADDR[ADDR_WIDTH-1:OFFS];

    // Look up the addressed word; a miss means the index is past DEPTH.
    always_comb begin
        req_hit   = 1'b0;
        req_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req_idx == IDX_W'(i)) begin
                req_hit   = 1'b1;
                req_rdata = mem_q[i];
            end
        end
    end

    // Bit mask of the lanes a completing write may touch.
    always_comb begin
        wmask = '1;
`ifdef APB_RAM_SLAVE_PSTRB_EN
        for (int b = 0; b < NBYTES; b++) begin
            wmask[b*8 +: 8] = {8{strb_q[b]}};
        end
`endif
    end

`ifdef APB_RAM_SLAVE_PSTRB_EN
    assign unused_bits = ^PADDR;
`else
    assign unused_bits = ^{PADDR, strb_q};
`endif

    // Transfer completes on the edge where the zero-wait access is strobed.
    assign done    = (state_q == ST_ACCESS) && (cnt_q == 4'd0)
                     && PSEL && PENABLE;
    assign PREADY  = done;
    assign PSLVERR = done && err_q;
    assign PRDATA  = prdata_q;

    // Next-state logic: capture at setup, count waits, complete or abort.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prdata_d = prdata_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                    idx_d   = req_idx;
                    wr_d    = PWRITE;
                    err_d   = !req_hit;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    if (!PWRITE) begin
                        prdata_d = req_hit ? req_rdata : '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (PENABLE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Memory next value: only a completing, in-range write changes a word.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (done && wr_q && !err_q && (idx_q == IDX_W'(i))) begin
                mem_d[i] = (mem_q[i] & ~wmask) | (wdata_q & wmask);
            end
        end
    end

    // Control and capture registers.
    always_ff @(posedge PCLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
        end
    end

    // RAM array; reset wipes every word so no partial write survives.
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (RST) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_apb_ram_slave.sv
// tb_apb_ram_slave: directed checks of apb_ram_slave at 0, 2 and 3 waits.
// Vector table on the zero-wait instance plus hand-written corner sequences.
module tb_apb_ram_slave;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

`ifdef APB_RAM_SLAVE_PSTRB_EN
    localparam logic [31:0] EXP_W2 = 32'hFF00FF00;
    localparam logic [31:0] EXP_W3 = 32'h00000000;
`else
    localparam logic [31:0] EXP_W2 = 32'h00000000;
    localparam logic [31:0] EXP_W3 = 32'hCAFEF00D;
`endif

    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        psel    [3];
    logic        penable [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    apb_ram_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .PCLK(clk), .RST(rst), .PADDR(paddr), .PWRITE(pwrite),
        .PSEL(psel[0]), .PENABLE(penable[0]), .PWDATA(pwdata),
        .PSTRB(pstrb), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0])
    );

    apb_ram_slave #(.WAIT_CYCLES(2)) u_dut2 (
        .PCLK(clk), .RST(rst), .PADDR(paddr), .PWRITE(pwrite),
        .PSEL(psel[1]), .PENABLE(penable[1]), .PWDATA(pwdata),
        .PSTRB(pstrb), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1])
    );

    apb_ram_slave #(.WAIT_CYCLES(3)) u_dut3 (
        .PCLK(clk), .RST(rst), .PADDR(paddr), .PWRITE(pwrite),
        .PSEL(psel[2]), .PENABLE(penable[2]), .PWDATA(pwdata),
        .PSTRB(pstrb), .PRDATA(prdata[2]), .PREADY(pready[2]),
        .PSLVERR(pslverr[2])
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Full transfer on instance k; entered and left at posedge+1.
    task automatic xfer(input int k, input logic wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic err,
                        output int waits);
        paddr      = a;
        pwrite     = wr;
        pwdata     = wd;
        pstrb      = st;
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        @(posedge clk); #1;
        penable[k] = 1'b1;
        #1;
        waits = 0;
        while (!pready[k] && waits < 20) begin
            @(posedge clk); #2;
            waits++;
        end
        err = pslverr[k];
        @(posedge clk); #1;
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
        rd = prdata[k];
    endtask

    vec_t        vecs [NV];
    logic [31:0] rd;
    logic [31:0] last_rd;
    logic        err;
    int          waits;
    int          c0;

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 8'h04, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 8'h07, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 8'h80, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 8'h80, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 8'h00, 32'h0,        4'hF, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 8'h08, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 8'h08, 32'h00000000, 4'h5, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 8'h08, 32'h0,        4'hF, EXP_W2,       1'b0};
        vecs[10] = '{1'b1, 8'h0C, 32'hCAFEF00D, 4'h0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 8'h0C, 32'h0,        4'hF, EXP_W3,       1'b0};
        vecs[12] = '{1'b1, 8'h7C, 32'h55AA55AA, 4'hF, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 8'h7F, 32'h0,        4'hF, 32'h55AA55AA, 1'b0};
        vecs[14] = '{1'b0, 8'hFC, 32'h0,        4'hF, 32'h0,        1'b1};

        rst    = 1'b1;
        paddr  = '0;
        pwrite = 1'b0;
        pwdata = '0;
        pstrb  = '0;
        for (int k = 0; k < 3; k++) begin
            psel[k]    = 1'b0;
            penable[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset prdata", prdata[0], 32'h0);
        check("reset pready", 32'(pready[0]), 32'h0);
        check("reset pslverr", 32'(pslverr[0]), 32'h0);

        last_rd = 32'h0;
        for (int i = 0; i < NV; i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 rd, err, waits);
            if (!vecs[i].wr) last_rd = vecs[i].exp_rd;
            check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d waits", i), waits, 0);
            check($sformatf("v%0d prdata", i), rd, last_rd);
        end

        // back-to-back write then read, no idle cycle
        c0 = cyc;
        xfer(0, 1'b1, 8'h08, 32'hA5A5A5A5, 4'hF, rd, err, waits);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'hF, rd, err, waits);
        check("b2b cycles", cyc - c0, 4);
        check("b2b prdata", rd, 32'hA5A5A5A5);
        check("b2b err", 32'(err), 32'h0);

        // three wait states
        xfer(2, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, err, waits);
        check("w3 write waits", waits, 3);
        xfer(2, 1'b0, 8'h04, 32'h0, 4'hF, rd, err, waits);
        check("w3 read waits", waits, 3);
        check("w3 prdata", rd, 32'hDEADBEEF);

        // two wait states: seed word 3, then abort a write to it
        xfer(1, 1'b1, 8'h0C, 32'h00002222, 4'hF, rd, err, waits);
        check("w2 seed waits", waits, 2);
        paddr      = 8'h0C;
        pwrite     = 1'b1;
        pwdata     = 32'h00001111;
        pstrb      = 4'hF;
        psel[1]    = 1'b1;
        penable[1] = 1'b0;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        #1;
        check("abort pready a0", 32'(pready[1]), 32'h0);
        @(posedge clk); #2;
        check("abort pready a1", 32'(pready[1]), 32'h0);
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        @(posedge clk); #1;
        check("abort pready idle", 32'(pready[1]), 32'h0);
        check("abort pslverr idle", 32'(pslverr[1]), 32'h0);
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'hF, rd, err, waits);
        check("abort read waits", waits, 2);
        check("abort word3", rd, 32'h00002222);

        // reset in the middle of a write
        paddr      = 8'h0C;
        pwrite     = 1'b1;
        pwdata     = 32'h00001111;
        pstrb      = 4'hF;
        psel[1]    = 1'b1;
        penable[1] = 1'b0;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        #1;
        check("rst pready", 32'(pready[1]), 32'h0);
        check("rst prdata", prdata[1], 32'h0);
        check("rst prdata dut0", prdata[0], 32'h0);
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'hF, rd, err, waits);
        check("rst read waits", waits, 2);
        check("rst word3", rd, 32'h0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, rd, err, waits);
        check("rst dut0 word1", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
